tlb_translate: RTL and testbench

- Set-associative TLB translating 32-bit virtual addresses with 4 KiB pages into physical addresses, checking read/write permissions.
- Sits between the processor load/store path and the page-table walker (PTW).
- Integrates:
  - control FSM,
  - entry storage,
  - tag lookup/permission check,
  - per-set LRU replacement.
- On a miss it requests a PTE from the PTW, fills an entry when permitted, then responds.

---
 rtl/tlb_translate.sv | 230 +++++++++++++++++++++++
 tb/tb_tlb_translate.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_translate.sv
// Set-associative TLB for 32-bit virtual addresses with 4 KiB pages.
// Misses are resolved through the page-table walker; permitted PTEs are filled with true-LRU replacement.
module tlb_translate #(
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int LRU_BITS       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] vaddr_i,
  input  logic        access_type_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] paddr_o,
  output logic        hit_o,
  output logic        fault_o,
  output logic        ptw_req_valid_o,
  input  logic        ptw_req_ready_i,
  output logic [31:0] ptw_vaddr_o,
  input  logic        ptw_resp_valid_i,
  output logic        ptw_resp_ready_o,
  input  logic [31:0] ptw_pte_i
);

  localparam int NUM_SETS = 1 << SET_INDEX_BITS;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [LRU_BITS-1:0] AGE_MAX = LRU_BITS'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOOKUP      = 3'd1,
    S_PTW_REQ     = 3'd2,
    S_PTW_PENDING = 3'd3,
    S_UPDATE      = 3'd4,
    S_RESPOND     = 3'd5
  } state_t;

  state_t      state_reg;
  logic [31:0] vaddr_reg;
  logic        access_reg;
  logic        pte_v_reg;
  logic [1:0]  pte_perm_reg;
  logic [19:0] pte_ppn_reg;

  // PTE bits [11:3] carry no meaning for this TLB.
  logic unused_pte_bits;
  assign unused_pte_bits = ^ptw_pte_i[11:3];

  logic [19:0]               req_vpn;
  logic [SET_INDEX_BITS-1:0] set_idx;
  assign req_vpn = vaddr_reg[31:12];
  assign set_idx = req_vpn[SET_INDEX_BITS-1:0];

  logic [NUM_WAYS-1:0] way_valid;
  logic [NUM_WAYS-1:0] way_match;
  logic [19:0]         way_ppn  [NUM_WAYS];
  logic [1:0]          way_perm [NUM_WAYS];
  logic [LRU_BITS-1:0] way_age  [NUM_WAYS];

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic [1:0]       hit_perm;
  logic             hit_fault;
  logic             pte_fault;
  logic             fill_en;
  logic             lookup_touch;
  logic             touch_en;
  logic [WAY_W-1:0] touch_way;
  logic [LRU_BITS-1:0] touch_age;

  // Descending scans so that the lowest matching index is the one kept.
  always_comb begin
    hit_any    = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_age[w] == AGE_MAX) victim_way = WAY_W'(w);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_way = WAY_W'(w);
    end
  end

  // Permission pairs are stored as {W,R}.
  assign hit_perm     = way_perm[hit_way];
  assign hit_fault    = access_reg ? !hit_perm[1] : !hit_perm[0];
  assign pte_fault    = access_reg ? !pte_perm_reg[1] : !pte_perm_reg[0];
  assign fill_en      = (state_reg == S_UPDATE) && pte_v_reg && !pte_fault;
  assign lookup_touch = (state_reg == S_LOOKUP) && hit_any && !hit_fault;
  assign touch_en     = lookup_touch || fill_en;
  assign touch_way    = fill_en ? victim_way : hit_way;

  always_comb begin
    touch_age = way_age[hit_way];
    if (fill_en) begin
      touch_age = way_valid[victim_way] ? way_age[victim_way] : AGE_MAX;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      logic                valid_reg [NUM_SETS];
      logic [19:0]         vpn_reg   [NUM_SETS];
      logic [19:0]         ppn_reg   [NUM_SETS];
      logic [1:0]          perm_reg  [NUM_SETS];
      logic [LRU_BITS-1:0] age_reg   [NUM_SETS];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < NUM_SETS; s++) begin
            valid_reg[s] <= 1'b0;
            vpn_reg[s]   <= '0;
            ppn_reg[s]   <= '0;
            perm_reg[s]  <= '0;
            age_reg[s]   <= LRU_BITS'(gi);
          end
        end else begin
          if (fill_en && (victim_way == WAY_W'(gi))) begin
            valid_reg[set_idx] <= 1'b1;
            vpn_reg[set_idx]   <= req_vpn;
            ppn_reg[set_idx]   <= pte_ppn_reg;
            perm_reg[set_idx]  <= pte_perm_reg;
          end
          // Ways younger than the touched way's old age get one step older.
          if (touch_en) begin
            if (touch_way == WAY_W'(gi)) begin
              age_reg[set_idx] <= '0;
            end else if (valid_reg[set_idx] && (age_reg[set_idx] < touch_age)) begin
              age_reg[set_idx] <= age_reg[set_idx] + LRU_BITS'(1);
            end
          end
        end
      end

      assign way_valid[gi] = valid_reg[set_idx];
      assign way_match[gi] = valid_reg[set_idx] && (vpn_reg[set_idx] == req_vpn);
      assign way_ppn[gi]   = ppn_reg[set_idx];
      assign way_perm[gi]  = perm_reg[set_idx];
      assign way_age[gi]   = age_reg[set_idx];
    end
  endgenerate

  assign req_ready_o      = (state_reg == S_IDLE);
  assign resp_valid_o     = (state_reg == S_RESPOND);
  assign ptw_req_valid_o  = (state_reg == S_PTW_REQ);
  assign ptw_resp_ready_o = (state_reg == S_PTW_PENDING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      vaddr_reg    <= '0;
      access_reg   <= 1'b0;
      pte_v_reg    <= 1'b0;
      pte_perm_reg <= '0;
      pte_ppn_reg  <= '0;
      paddr_o      <= '0;
      hit_o        <= 1'b0;
      fault_o      <= 1'b0;
      ptw_vaddr_o  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid_i) begin
            vaddr_reg  <= vaddr_i;
            access_reg <= access_type_i;
            state_reg  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_any) begin
            hit_o     <= 1'b1;
            fault_o   <= hit_fault;
            paddr_o   <= hit_fault ? 32'd0 : {way_ppn[hit_way], vaddr_reg[11:0]};
            state_reg <= S_RESPOND;
          end else begin
            ptw_vaddr_o <= vaddr_reg;
            state_reg   <= S_PTW_REQ;
          end
        end
        S_PTW_REQ: begin
          if (ptw_req_ready_i) state_reg <= S_PTW_PENDING;
        end
        S_PTW_PENDING: begin
          if (ptw_resp_valid_i) begin
            pte_v_reg    <= ptw_pte_i[0];
            pte_perm_reg <= ptw_pte_i[2:1];
            pte_ppn_reg  <= ptw_pte_i[31:12];
            state_reg    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!pte_v_reg) begin
            paddr_o <= '0;
            hit_o   <= 1'b0;
            fault_o <= 1'b1;
          end else if (pte_fault) begin
            paddr_o <= '0;
            hit_o   <= 1'b1;
            fault_o <= 1'b1;
          end else begin
            paddr_o <= {pte_ppn_reg, vaddr_reg[11:0]};
            hit_o   <= 1'b1;
            fault_o <= 1'b0;
          end
          state_reg <= S_RESPOND;
        end
        S_RESPOND: begin
          if (resp_ready_i) begin
            paddr_o   <= '0;
            hit_o     <= 1'b0;
            fault_o   <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_translate.sv
// Scenario bench for tlb_translate: expected responses are queued on issue and checked on completion.
module tb_tlb_translate;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] vaddr_i;
  logic        access_type_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] paddr_o;
  logic        hit_o;
  logic        fault_o;
  logic        ptw_req_valid_o;
  logic        ptw_req_ready_i;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_resp_valid_i;
  logic        ptw_resp_ready_o;
  logic [31:0] ptw_pte_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [31:0] paddr;
    logic        hit;
    logic        fault;
    logic [7:0]  ptw_reqs;
    logic [31:0] ptw_vaddr;
  } exp_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        hit;
    logic        fault;
    logic [7:0]  ptw_reqs;
    logic [31:0] ptw_vaddr;
    logic        unstable;
    logic        early_ready;
    logic        timeout;
    logic [15:0] req_lat;
    logic [15:0] pte_lat;
  } txn_t;

  exp_t exp_q[$];

  tlb_translate dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .vaddr_i(vaddr_i), .access_type_i(access_type_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .paddr_o(paddr_o), .hit_o(hit_o), .fault_o(fault_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_vaddr_o(ptw_vaddr_o),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_ready_o(ptw_resp_ready_o),
    .ptw_pte_i(ptw_pte_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request end to end and records what the DUT did; entered and left #1 after a rising edge.
  task automatic run_txn(input logic [31:0] va, input logic acc, input logic [31:0] pte,
                         input int ptw_hold, input int rsp_hold, output txn_t r);
    int n, ph, rh, acc_cyc, pte_cyc;
    bit done;
    r = '0; ph = 0; rh = 0; done = 0; pte_cyc = 0;
    req_valid_i = 1'b1; vaddr_i = va; access_type_i = acc;
    n = 0;
    while (!req_ready_o && n < 20) begin @(posedge clk); #1; n++; end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0; resp_ready_i = 1'b0;
      if (req_ready_o) r.early_ready = 1'b1;
      if (ptw_req_valid_o) begin
        if (ph == 0) r.ptw_vaddr = ptw_vaddr_o;
        else if (ptw_vaddr_o !== r.ptw_vaddr) r.unstable = 1'b1;
        if (ph >= ptw_hold) begin ptw_req_ready_i = 1'b1; r.ptw_reqs = r.ptw_reqs + 8'd1; end
        ph++;
      end
      if (ptw_resp_ready_o) begin ptw_resp_valid_i = 1'b1; ptw_pte_i = pte; pte_cyc = cyc; end
      if (resp_valid_o) begin
        if (rh == 0) begin
          r.paddr = paddr_o; r.hit = hit_o; r.fault = fault_o;
          r.req_lat = 16'(cyc - acc_cyc); r.pte_lat = 16'(cyc - pte_cyc);
        end else if ({paddr_o, hit_o, fault_o} !== {r.paddr, r.hit, r.fault}) begin
          r.unstable = 1'b1;
        end
        if (rh >= rsp_hold) begin resp_ready_i = 1'b1; done = 1; end
        rh++;
      end
      @(posedge clk); #1;
      n++;
    end
    ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0; resp_ready_i = 1'b0;
    r.timeout = !done;
    $display("txn va=%h acc=%b paddr=%h hit=%b fault=%b ptw_reqs=%0d req_lat=%0d",
             va, acc, r.paddr, r.hit, r.fault, r.ptw_reqs, r.req_lat);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({req_ready_o, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o} !== 4'b1000) begin
      n_err++; $display("FAIL reset_handshake got=%b exp=1000",
                        {req_ready_o, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o});
    end
    n_cmp++;
    if ({paddr_o, hit_o, fault_o, ptw_vaddr_o} !== 66'd0) begin
      n_err++; $display("FAIL reset_outputs paddr=%h hit=%b fault=%b ptw_vaddr=%h exp all zero",
                        paddr_o, hit_o, fault_o, ptw_vaddr_o);
    end
  endtask

  task automatic test_cold_read();
    txn_t r; exp_t e;
    exp_q.push_back('{paddr: 32'h000A_B123, hit: 1'b1, fault: 1'b0, ptw_reqs: 8'd1, ptw_vaddr: 32'h0000_5123});
    run_txn(32'h0000_5123, 1'b0, 32'h000A_B007, 0, 0, r);
    e = exp_q.pop_front();
    n_cmp++;
    if (r.timeout || {r.paddr, r.hit, r.fault} !== {e.paddr, e.hit, e.fault}) begin
      n_err++; $display("FAIL cold_resp paddr=%h hit=%b fault=%b to=%b exp paddr=%h hit=%b fault=%b",
                        r.paddr, r.hit, r.fault, r.timeout, e.paddr, e.hit, e.fault);
    end
    n_cmp++;
    if ({r.ptw_reqs, r.ptw_vaddr} !== {e.ptw_reqs, e.ptw_vaddr}) begin
      n_err++; $display("FAIL cold_ptw reqs=%0d vaddr=%h exp reqs=%0d vaddr=%h",
                        r.ptw_reqs, r.ptw_vaddr, e.ptw_reqs, e.ptw_vaddr);
    end
    n_cmp++;
    if (r.pte_lat !== 16'd2) begin
      n_err++; $display("FAIL cold_pte_latency got=%0d exp=2", r.pte_lat);
    end
    exp_q.push_back('{paddr: 32'h000A_B123, hit: 1'b1, fault: 1'b0, ptw_reqs: 8'd0, ptw_vaddr: 32'h0});
    run_txn(32'h0000_5123, 1'b0, 32'h0, 0, 0, r);
    e = exp_q.pop_front();
    n_cmp++;
    if (r.timeout || {r.paddr, r.hit, r.fault, r.ptw_reqs} !== {e.paddr, e.hit, e.fault, e.ptw_reqs}) begin
      n_err++; $display("FAIL warm_resp paddr=%h hit=%b fault=%b ptw=%0d exp paddr=%h hit=%b fault=%b ptw=%0d",
                        r.paddr, r.hit, r.fault, r.ptw_reqs, e.paddr, e.hit, e.fault, e.ptw_reqs);
    end
    n_cmp++;
    if (r.req_lat !== 16'd2) begin
      n_err++; $display("FAIL warm_latency got=%0d exp=2", r.req_lat);
    end
  endtask

  task automatic test_perm_fault();
    logic [31:0] va_t  [4] = '{32'h0000_6004, 32'h0000_6004, 32'h0000_8000, 32'h0000_8010};
    logic        acc_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] pte_t [4] = '{32'h0001_2003, 32'h0001_2003, 32'h0003_3003, 32'h0};
    logic [31:0] pa_t  [4] = '{32'h0, 32'h0, 32'h0003_3000, 32'h0};
    logic        flt_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  ptw_t [4] = '{8'd1, 8'd1, 8'd1, 8'd0};
    txn_t r; exp_t e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{paddr: pa_t[i], hit: 1'b1, fault: flt_t[i], ptw_reqs: ptw_t[i], ptw_vaddr: va_t[i]});
      run_txn(va_t[i], acc_t[i], pte_t[i], 0, 0, r);
      e = exp_q.pop_front();
      n_cmp++;
      if (r.timeout || {r.paddr, r.hit, r.fault, r.ptw_reqs} !== {e.paddr, e.hit, e.fault, e.ptw_reqs}) begin
        n_err++; $display("FAIL perm_%0d paddr=%h hit=%b fault=%b ptw=%0d exp paddr=%h hit=%b fault=%b ptw=%0d",
                          i, r.paddr, r.hit, r.fault, r.ptw_reqs, e.paddr, e.hit, e.fault, e.ptw_reqs);
      end
    end
  endtask

  task automatic test_invalid_pte();
    txn_t r; exp_t e;
    exp_q.push_back('{paddr: 32'h0, hit: 1'b0, fault: 1'b1, ptw_reqs: 8'd1, ptw_vaddr: 32'h0000_7000});
    run_txn(32'h0000_7000, 1'b0, 32'h0, 0, 0, r);
    e = exp_q.pop_front();
    n_cmp++;
    if (r.timeout || {r.paddr, r.hit, r.fault, r.ptw_reqs, r.ptw_vaddr} !==
        {e.paddr, e.hit, e.fault, e.ptw_reqs, e.ptw_vaddr}) begin
      n_err++; $display("FAIL invalid_pte paddr=%h hit=%b fault=%b ptw=%0d exp paddr=%h hit=%b fault=%b ptw=%0d",
                        r.paddr, r.hit, r.fault, r.ptw_reqs, e.paddr, e.hit, e.fault, e.ptw_reqs);
    end
  endtask

  task automatic test_lru();
    logic [31:0] va_t  [8] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                               32'h0000_0000, 32'h0004_0000, 32'h0001_0000, 32'h0000_0000};
    logic [31:0] pte_t [8] = '{32'h0010_0007, 32'h0010_1007, 32'h0010_2007, 32'h0010_3007,
                               32'h0, 32'h0010_4007, 32'h0011_1007, 32'h0};
    logic [31:0] pa_t  [8] = '{32'h0010_0000, 32'h0010_1000, 32'h0010_2000, 32'h0010_3000,
                               32'h0010_0000, 32'h0010_4000, 32'h0011_1000, 32'h0010_0000};
    logic [7:0]  ptw_t [8] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0};
    txn_t r; exp_t e;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{paddr: pa_t[i], hit: 1'b1, fault: 1'b0, ptw_reqs: ptw_t[i], ptw_vaddr: va_t[i]});
      run_txn(va_t[i], 1'b0, pte_t[i], 0, 0, r);
      e = exp_q.pop_front();
      n_cmp++;
      if (r.timeout || {r.paddr, r.hit, r.fault, r.ptw_reqs} !== {e.paddr, e.hit, e.fault, e.ptw_reqs}) begin
        n_err++; $display("FAIL lru_%0d va=%h paddr=%h hit=%b ptw=%0d exp paddr=%h hit=%b ptw=%0d",
                          i, va_t[i], r.paddr, r.hit, r.ptw_reqs, e.paddr, e.hit, e.ptw_reqs);
      end
    end
  endtask

  task automatic test_backpressure();
    txn_t r; exp_t e;
    exp_q.push_back('{paddr: 32'h0004_4abc, hit: 1'b1, fault: 1'b0, ptw_reqs: 8'd1, ptw_vaddr: 32'h0000_9abc});
    run_txn(32'h0000_9abc, 1'b0, 32'h0004_4007, 5, 3, r);
    e = exp_q.pop_front();
    n_cmp++;
    if (r.timeout || {r.paddr, r.hit, r.fault, r.ptw_reqs, r.ptw_vaddr} !==
        {e.paddr, e.hit, e.fault, e.ptw_reqs, e.ptw_vaddr}) begin
      n_err++; $display("FAIL bp_resp paddr=%h ptw=%0d ptw_va=%h exp paddr=%h ptw=%0d ptw_va=%h",
                        r.paddr, r.ptw_reqs, r.ptw_vaddr, e.paddr, e.ptw_reqs, e.ptw_vaddr);
    end
    n_cmp++;
    if ({r.unstable, r.early_ready} !== 2'b00) begin
      n_err++; $display("FAIL bp_stability unstable=%b early_ready=%b exp 0 0", r.unstable, r.early_ready);
    end
    n_cmp++;
    if ({paddr_o, hit_o, fault_o} !== 34'd0) begin
      n_err++; $display("FAIL bp_clear paddr=%h hit=%b fault=%b exp zero", paddr_o, hit_o, fault_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va_t  [4] = '{32'h0000_5123, 32'h0000_9ff0, 32'h0000_0abc, 32'h0000_8010};
    logic        acc_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] pa_t  [4] = '{32'h000A_B123, 32'h0004_4ff0, 32'h0010_0abc, 32'h0};
    logic        flt_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    txn_t r; exp_t e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{paddr: pa_t[i], hit: 1'b1, fault: flt_t[i], ptw_reqs: 8'd0, ptw_vaddr: 32'h0});
      run_txn(va_t[i], acc_t[i], 32'h0, 0, 0, r);
      e = exp_q.pop_front();
      n_cmp++;
      if (r.timeout || r.req_lat !== 16'd2 ||
          {r.paddr, r.hit, r.fault, r.ptw_reqs} !== {e.paddr, e.hit, e.fault, e.ptw_reqs}) begin
        n_err++; $display("FAIL b2b_%0d paddr=%h hit=%b fault=%b ptw=%0d lat=%0d exp paddr=%h hit=1 fault=%b ptw=0 lat=2",
                          i, r.paddr, r.hit, r.fault, r.ptw_reqs, r.req_lat, e.paddr, e.fault);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    txn_t r; exp_t e;
    req_valid_i = 1'b1; vaddr_i = 32'h0000_A000; access_type_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (!ptw_req_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    ptw_req_ready_i = 1'b1;
    @(posedge clk); #1;
    ptw_req_ready_i = 1'b0;
    n_cmp++;
    if (ptw_resp_ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_reach_pending ptw_resp_ready=%b exp=1", ptw_resp_ready_o);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready_o, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o} !== 4'b1000 ||
        {paddr_o, hit_o, fault_o, ptw_vaddr_o} !== 66'd0) begin
      n_err++; $display("FAIL rst_mid_state hs=%b paddr=%h hit=%b fault=%b ptw_va=%h exp hs=1000 rest zero",
                        {req_ready_o, resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o},
                        paddr_o, hit_o, fault_o, ptw_vaddr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{paddr: 32'h000A_B123, hit: 1'b1, fault: 1'b0, ptw_reqs: 8'd1, ptw_vaddr: 32'h0000_5123});
    run_txn(32'h0000_5123, 1'b0, 32'h000A_B007, 0, 0, r);
    e = exp_q.pop_front();
    n_cmp++;
    if (r.timeout || {r.paddr, r.hit, r.fault, r.ptw_reqs, r.ptw_vaddr} !==
        {e.paddr, e.hit, e.fault, e.ptw_reqs, e.ptw_vaddr}) begin
      n_err++; $display("FAIL rst_mid_refetch paddr=%h ptw=%0d ptw_va=%h exp paddr=%h ptw=%0d ptw_va=%h",
                        r.paddr, r.ptw_reqs, r.ptw_vaddr, e.paddr, e.ptw_reqs, e.ptw_vaddr);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 1'b0; vaddr_i = '0; access_type_i = 1'b0;
    resp_ready_i = 1'b0; ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0; ptw_pte_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_cold_read();
    test_perm_fault();
    test_invalid_pte();
    test_lru();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
